// File: rtl/modexp_arbiter.sv
// Round-robin arbiter/sequencer that shares one mod_exp unit between keygen, sign_gen and verify.
// Latches the winner's operands, runs mod_exp under a watchdog and returns done/err to the owner.
module modexp_arbiter #(
    parameter int LEN     = 32,
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*LEN-1:0] req_base,
    input  logic [N_REQ*LEN-1:0] req_exp,
    input  logic [N_REQ*LEN-1:0] req_mod,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic [LEN-1:0]       result,
    output logic                 busy,
    output logic                 exp_rst,
    output logic                 exp_start,
    output logic [LEN-1:0]       exp_base,
    output logic [LEN-1:0]       exp_exp,
    output logic [LEN-1:0]       exp_mod,
    input  logic [LEN-1:0]       exp_out,
    input  logic                 exp_done
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_rr_ptr;
    logic [15:0]        r_timer;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_done;
    logic [N_REQ-1:0]   r_err;
    logic [LEN-1:0]     r_result;
    logic               r_exp_rst;
    logic               r_exp_start;
    logic [LEN-1:0]     r_exp_base;
    logic [LEN-1:0]     r_exp_exp;
    logic [LEN-1:0]     r_exp_mod;

    logic [LEN-1:0]     w_base [N_REQ];
    logic [LEN-1:0]     w_exp  [N_REQ];
    logic [LEN-1:0]     w_mod  [N_REQ];
    logic [OW-1:0]      w_cand [N_REQ];
    logic               w_found;
    logic [OW-1:0]      w_pick;
    logic [N_REQ-1:0]   w_owner_oh;

    // w_cand[gi] is the requester examined gi+1 steps after the last served one
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_base[gi] = req_base[gi*LEN +: LEN];
            assign w_exp[gi]  = req_exp[gi*LEN +: LEN];
            assign w_mod[gi]  = req_mod[gi*LEN +: LEN];
            assign w_cand[gi] = OW'((int'(r_rr_ptr) + gi + 1) % N_REQ);
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req[w_cand[k]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[k];
            end
        end
    end

    assign w_owner_oh = N_REQ'(1) << r_owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= OW'(N_REQ - 1);
            r_timer     <= '0;
            r_grant     <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_result    <= '0;
            r_exp_rst   <= 1'b1;
            r_exp_start <= 1'b0;
            r_exp_base  <= '0;
            r_exp_exp   <= '0;
            r_exp_mod   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    r_exp_rst   <= 1'b1;
                    r_exp_start <= 1'b0;
                    r_grant     <= '0;
                    if (w_found) begin
                        r_owner    <= w_pick;
                        r_grant    <= N_REQ'(1) << w_pick;
                        r_exp_base <= w_base[w_pick];
                        r_exp_exp  <= w_exp[w_pick];
                        r_exp_mod  <= w_mod[w_pick];
                        r_timer    <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_exp_rst   <= 1'b0;
                    r_exp_start <= 1'b1;
                    r_timer     <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    // completion outranks both abort and watchdog in the same cycle
                    if (exp_done) begin
                        r_result    <= exp_out;
                        r_done      <= w_owner_oh;
                        r_exp_start <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (!req[r_owner]) begin
                        r_exp_rst   <= 1'b1;
                        r_exp_start <= 1'b0;
                        r_grant     <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_err       <= w_owner_oh;
                        r_exp_rst   <= 1'b1;
                        r_exp_start <= 1'b0;
                        r_grant     <= '0;
                        r_rr_ptr    <= r_owner;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_RESP: begin
                    r_grant   <= '0;
                    r_rr_ptr  <= r_owner;
                    r_exp_rst <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign busy      = (r_state != S_IDLE);
    assign exp_rst   = r_exp_rst;
    assign exp_start = r_exp_start;
    assign exp_base  = r_exp_base;
    assign exp_exp   = r_exp_exp;
    assign exp_mod   = r_exp_mod;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Directed bench for modexp_arbiter: the bench plays mod_exp, driving exp_done/exp_out by hand.
module tb_modexp_arbiter;

    localparam int LEN = 32;
    localparam int N_REQ = 3;
    localparam int TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req;
    logic [N_REQ*LEN-1:0] req_base, req_exp, req_mod;
    logic [N_REQ-1:0]     grant, done, err;
    logic [LEN-1:0]       result;
    logic                 busy, exp_rst, exp_start;
    logic [LEN-1:0]       exp_base, exp_exp, exp_mod;
    logic [LEN-1:0]       exp_out;
    logic                 exp_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    modexp_arbiter #(.LEN(LEN), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_base(req_base), .req_exp(req_exp), .req_mod(req_mod),
        .grant(grant), .done(done), .err(err), .result(result), .busy(busy),
        .exp_rst(exp_rst), .exp_start(exp_start),
        .exp_base(exp_base), .exp_exp(exp_exp), .exp_mod(exp_mod),
        .exp_out(exp_out), .exp_done(exp_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_ops(input int k, input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        req_base[k*LEN +: LEN] = b;
        req_exp[k*LEN +: LEN]  = e;
        req_mod[k*LEN +: LEN]  = m;
    endtask

    task automatic wait_grant(input int k);
        int n;
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", (grant != '0), 1);
        check("grant_owner", grant, 64'(1) << k);
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!exp_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", exp_start, 1);
    endtask

    task automatic serve(input int lat, input logic [31:0] val);
        wait_start();
        repeat (lat) @(negedge clk);
        exp_done = 1'b1;
        exp_out  = val;
        @(negedge clk);
        exp_done = 1'b0;
    endtask

    task automatic finish_txn(input int k, input logic [31:0] val, input bit drop);
        serve(2, val);
        check("done_owner", done, 64'(1) << k);
        check("done_result", result, val);
        check("done_no_err", err, 0);
        check("done_grant", grant, 64'(1) << k);
        if (drop) req[k] = 1'b0;
        @(negedge clk);
        check("post_done", done, 0);
        check("post_grant", grant, 0);
        check("post_busy", busy, 0);
        check("post_exp_rst", exp_rst, 1);
        $display("txn owner=%0d result=%0h", k, result);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        req = '0;
        req_base = '0;
        req_exp = '0;
        req_mod = '0;
        exp_out = '0;
        exp_done = 1'b0;
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_exp_rst", exp_rst, 1);
        check("rst_exp_start", exp_start, 0);
        check("rst_exp_base", exp_base, 0);
        rst = 1'b1;
        $display("txn reset");

        // Single request: 2^10 mod 1019 = 5
        set_ops(1, 32'd2, 32'd10, 32'd1019);
        req = 3'b010;
        wait_grant(1);
        check("t1_busy", busy, 1);
        check("t1_load_rst", exp_rst, 1);
        check("t1_load_start", exp_start, 0);
        check("t1_base", exp_base, 2);
        check("t1_exp", exp_exp, 10);
        check("t1_mod", exp_mod, 1019);
        set_ops(1, 32'd99, 32'd99, 32'd99);
        @(negedge clk);
        check("t1_run_start", exp_start, 1);
        check("t1_run_rst", exp_rst, 0);
        finish_txn(1, 32'd5, 1);
        check("t1_operand_hold", exp_base, 2);

        // Contention from reset: 0,1,2 then 0,2
        do_reset();
        set_ops(0, 32'h10, 32'h11, 32'h12);
        set_ops(1, 32'h20, 32'h21, 32'h22);
        set_ops(2, 32'h30, 32'h31, 32'h32);
        req = 3'b111;
        wait_grant(0);
        check("t2_base0", exp_base, 32'h10);
        finish_txn(0, 32'hA0, 1);
        wait_grant(1);
        check("t2_mod1", exp_mod, 32'h22);
        finish_txn(1, 32'hA1, 1);
        wait_grant(2);
        check("t2_exp2", exp_exp, 32'h31);
        req[0] = 1'b1;
        finish_txn(2, 32'hA2, 0);
        wait_grant(0);
        finish_txn(0, 32'hB0, 1);
        wait_grant(2);
        finish_txn(2, 32'hB2, 1);

        // Watchdog: 16 RUN cycles then err, result untouched
        req = 3'b010;
        wait_grant(1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (err != '0) break;
            if (exp_start) cnt++;
        end
        check("t3_run_cycles", cnt, 16);
        check("t3_err", err, 3'b010);
        check("t3_no_done", done, 0);
        check("t3_exp_rst", exp_rst, 1);
        check("t3_result", result, 32'hB2);
        check("t3_grant", grant, 0);
        @(negedge clk);
        check("t3_err_pulse", err, 0);
        req = '0;
        $display("txn timeout owner=1");

        // Abort on RUN cycle 5, then requester 2 is served
        do_reset();
        req = 3'b101;
        wait_grant(0);
        wait_start();
        repeat (4) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        check("t4_grant", grant, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_err", err, 0);
        check("t4_exp_rst", exp_rst, 1);
        $display("txn abort owner=0");
        wait_grant(2);
        finish_txn(2, 32'hC2, 1);

        // exp_done on the watchdog cycle: done wins
        req = 3'b001;
        wait_grant(0);
        wait_start();
        repeat (15) @(negedge clk);
        exp_done = 1'b1;
        exp_out = 32'hABCD;
        @(negedge clk);
        exp_done = 1'b0;
        check("t5_done", done, 3'b001);
        check("t5_err", err, 0);
        check("t5_result", result, 32'hABCD);
        req = '0;
        @(negedge clk);
        check("t5_err_after", err, 0);
        check("t5_done_after", done, 0);
        $display("txn corner owner=0 result=%0h", result);

        // Asynchronous reset mid-RUN
        req = 3'b010;
        wait_grant(1);
        wait_start();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_grant", grant, 0);
        check("t6_busy", busy, 0);
        check("t6_exp_rst", exp_rst, 1);
        check("t6_exp_start", exp_start, 0);
        check("t6_result", result, 0);
        check("t6_exp_base", exp_base, 0);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("t6_idle", busy, 0);
        $display("txn async reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
